// File: rtl/fp_add_normalizer.sv
// Post-adder normalize/round stage of the single-precision FP adder.
// Two-register pipeline (S1 = operand + leading-zero count, S2 = packed
// result) with valid/ready on both sides. Rounding is round-to-nearest-even
// using only the bit shifted out on a carry; there is no sticky bit here.

// 25-bit logarithmic left shifter: one conditional power-of-two stage per
// shift-amount bit.
module shifter_left_25bits #(
  parameter int W    = 25,
  parameter int SH_W = 5
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  // Cascade of shift-by-2^k stages selected by shamt[k].
  always_comb begin
    dout = din;
    for (int k = 0; k < SH_W; k++) begin
      if (shamt[k]) dout = dout << (1 << k);
    end
  end

endmodule

module fp_add_normalizer #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 25,
  parameter int BIAS_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-3:0] out_frac,
  output logic [2:0]       out_flags
);

  localparam int LZ_W = $clog2(MAN_W);
  localparam int XW   = EXP_W + 2;

  // Handshake terms
  logic s1_ready;
  logic s2_ready;

  // Stage S1 registers
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic [MAN_W-1:0] s1_mant_q,  s1_mant_d;
  logic             s1_carry_q, s1_carry_d;
  logic [LZ_W-1:0]  s1_lz_q,    s1_lz_d;

  // Stage S2 (output) registers
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q,  out_sign_d;
  logic [EXP_W-1:0] out_exp_q,   out_exp_d;
  logic [MAN_W-3:0] out_frac_q,  out_frac_d;
  logic [2:0]       out_flags_q, out_flags_d;

  // Input-side leading-zero count and S2 result datapath
  logic [LZ_W-1:0]  lz_c;
  logic [MAN_W-1:0] shl_mant;
  logic [MAN_W-1:0] norm_m;
  logic [XW-1:0]    exp_adj;
  logic             round_up;
  logic             uflow;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-3:0] res_frac;
  logic [2:0]       res_flags;

  // Pipeline ready chain: a stage can load when empty or when the stage after it drains.
  always_comb begin
    s2_ready = ~out_valid_q | out_ready;
    s1_ready = ~s1_valid_q | s2_ready;
    in_ready = s1_ready;
  end

  // Leading-zero count of mant[23:0]; the highest set bit wins, all-zero gives 24.
  always_comb begin
    lz_c = LZ_W'(MAN_W - 1);
    for (int i = 0; i < MAN_W - 1; i++) begin
      if (in_mant[i]) lz_c = LZ_W'(MAN_W - 2 - i);
    end
  end

  // S1 next-state: capture a beat when S1 can accept, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_carry_d = s1_carry_q;
    s1_lz_d    = s1_lz_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = in_sign;
        s1_exp_d   = in_exp;
        s1_mant_d  = in_mant;
        s1_carry_d = in_mant[MAN_W-1];
        s1_lz_d    = lz_c;
      end
    end
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_carry_q <= 1'b0;
      s1_lz_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_carry_q <= s1_carry_d;
      s1_lz_q    <= s1_lz_d;
    end
  end

  shifter_left_25bits #(
    .W    (MAN_W),
    .SH_W (LZ_W)
  ) u_shl (
    .din   (s1_mant_q),
    .shamt (s1_lz_q),
    .dout  (shl_mant)
  );

  // Normalize, round and classify the S1 operand. The exponent is carried two
  // bits wider so both +2 overflow and a negative exp-lz stay distinguishable.
  always_comb begin
    norm_m    = s1_mant_q;
    exp_adj   = XW'(s1_exp_q);
    round_up  = 1'b0;
    uflow     = 1'b0;
    res_exp   = '0;
    res_frac  = '0;
    res_flags = 3'b000;
    if (s1_carry_q) begin
      norm_m   = s1_mant_q >> 1;
      exp_adj  = XW'(s1_exp_q) + XW'(1);
      round_up = s1_mant_q[0] & norm_m[0];
      if (round_up) norm_m = norm_m + MAN_W'(1);
      if (norm_m[MAN_W-1]) begin
        norm_m  = norm_m >> 1;
        exp_adj = exp_adj + XW'(1);
      end
    end else if (s1_lz_q != '0) begin
      norm_m  = shl_mant;
      exp_adj = XW'(s1_exp_q) - XW'(s1_lz_q);
      uflow   = (s1_exp_q <= EXP_W'(s1_lz_q));
    end

    if (s1_mant_q == '0) begin
      res_flags = 3'b100;
    end else if (uflow) begin
      res_flags = 3'b110;
    end else if (exp_adj >= XW'(BIAS_MAX)) begin
      res_exp   = EXP_W'(BIAS_MAX);
      res_flags = 3'b001;
    end else begin
      res_exp  = exp_adj[EXP_W-1:0];
      res_frac = norm_m[MAN_W-3:0];
    end
  end

  // S2 next-state: load the computed result when the output slot is free or popping.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    out_flags_d = out_flags_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_d  = s1_sign_q;
        out_exp_d   = res_exp;
        out_frac_d  = res_frac;
        out_flags_d = res_flags;
      end
    end
  end

  // S2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_flags_q <= 3'b000;
    end else begin
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Output drive
  always_comb begin
    out_valid = out_valid_q;
    out_sign  = out_sign_q;
    out_exp   = out_exp_q;
    out_frac  = out_frac_q;
    out_flags = out_flags_q;
  end

endmodule
